// File: rtl/uart_ram_loader.sv
// -----------------------------------------------------------------------------
// uart_ram_loader
//
// Serial program loader that acts as the write-side initiator for a dual-port
// generic_ram. It receives a framed image over UART 8N1, writes the payload
// into RAM starting at LOAD_BASE, and holds the 6502 core off while a load is
// in progress. It flags success or failure using a checksum plus frame and
// timeout checks.
//
// Frame on the wire: 0xA5, LEN_HI, LEN_LO, LEN data bytes, CSUM.
// CSUM is the sum of the data bytes modulo 256.
//
// Ports
//   clk        in   1           system clock; also drives the generic_ram wclk
//   rst        in   1           asynchronous, active-high reset
//   rx         in   1           UART receive line; idle high; asynchronous to clk
//   ram_waddr  out  ADDR_WIDTH  RAM write address; held while ram_we is low
//   ram_din    out  DATA_WIDTH  RAM write data; held while ram_we is low
//   ram_we     out  1           single-cycle write pulse per data byte
//   cpu_hold   out  1           high while a frame is being loaded
//   load_done  out  1           sticky: last frame loaded with a correct checksum
//   load_err   out  1           sticky: last frame aborted (checksum/frame/timeout)
//
// Both FSMs keep their state in the typed signals rx_state and ld_state.
// These are the points where checkers bind.
// -----------------------------------------------------------------------------
module uart_ram_loader #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE    = ADDR_WIDTH'(16'h0600),
    parameter int                    CLK_DIV      = 104,
    parameter int                    TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int HALF     = CLK_DIV / 2;
    localparam int TO_LIMIT = TIMEOUT_BITS * CLK_DIV;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LEN_HI,
        L_LEN_LO,
        L_DATA,
        L_CSUM
    } ld_state_t;

    // -------------------------------------------------------------------------
    // rx synchroniser and falling-edge detect. All stages are preset to 1 so
    // that a reset never shows up as a start bit.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // -------------------------------------------------------------------------
    // UART receiver
    //
    // Handshake towards the loader: byte_vld is a one-cycle strobe with no
    // ready. rx_byte is valid in the strobe cycle and stays stable until the
    // first data bit of the next byte is shifted in. frame_err is a one-cycle
    // strobe and is mutually exclusive with byte_vld. Both strobes fire in the
    // cycle after the stop-bit sample.
    // -------------------------------------------------------------------------
    rx_state_t        rx_state;
    rx_state_t        rx_state_nx;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_byte;
    logic             byte_vld;
    logic             frame_err;

    logic             div_half;
    logic             div_full;
    logic             start_smp;
    logic             data_smp;
    logic             stop_smp;
    logic             div_clr;

    assign div_half = (div_cnt == DIV_W'(HALF - 1));
    assign div_full = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nx = RX_START;
            // A start bit that is already high again at mid-bit is a glitch.
            // Go back to watching the idle line; this is not an error.
            RX_START: if (div_half) rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (div_full && bit_cnt == 3'd7) rx_state_nx = RX_STOP;
            RX_STOP:  if (div_full) rx_state_nx = RX_IDLE;
            default:  rx_state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        start_smp = (rx_state == RX_START) && div_half;
        data_smp  = (rx_state == RX_DATA)  && div_full;
        stop_smp  = (rx_state == RX_STOP)  && div_full;
        // The counter sits at zero while idle. Each sample point restarts it,
        // so the next sample lands one full bit later at the bit centre.
        div_clr   = (rx_state == RX_IDLE) || start_smp || data_smp || stop_smp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            div_cnt   <= div_clr ? '0 : div_cnt + DIV_W'(1);
            if (start_smp) bit_cnt <= '0;
            else if (data_smp) bit_cnt <= bit_cnt + 3'd1;
            if (data_smp) rx_byte <= {rx_sync, rx_byte[7:1]};
            byte_vld  <= stop_smp &  rx_sync;
            frame_err <= stop_smp & ~rx_sync;
        end
    end

    // -------------------------------------------------------------------------
    // Inter-byte timeout. This counts clk cycles during which the receiver is
    // idle while a frame is open. It restarts whenever a start bit is being
    // received.
    // -------------------------------------------------------------------------
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    ld_state_t       ld_state;
    ld_state_t       ld_state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (ld_state == L_IDLE || rx_state != RX_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout = (ld_state != L_IDLE) && (rx_state == RX_IDLE) &&
                     (to_cnt == TO_W'(TO_LIMIT - 1));

    // -------------------------------------------------------------------------
    // Frame loader FSM
    // -------------------------------------------------------------------------
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] index;
    logic [7:0]  sum;

    logic        start_frame;
    logic        len_hi_ld;
    logic        len_lo_ld;
    logic        data_wr;
    logic        done_set;
    logic        err_set;
    logic        abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ld_state <= L_IDLE;
        else     ld_state <= ld_state_nx;
    end

    always_comb begin
        ld_state_nx = ld_state;
        unique case (ld_state)
            L_IDLE:   if (byte_vld && rx_byte == 8'hA5) ld_state_nx = L_LEN_HI;
            L_LEN_HI: if (byte_vld) ld_state_nx = L_LEN_LO;
            L_LEN_LO: if (byte_vld)
                          ld_state_nx = ({len_hi, rx_byte} == 16'd0) ? L_CSUM : L_DATA;
            L_DATA:   if (byte_vld && (index + 16'd1) == len) ld_state_nx = L_CSUM;
            L_CSUM:   if (byte_vld) ld_state_nx = L_IDLE;
            default:  ld_state_nx = L_IDLE;
        endcase
        // Frame errors and timeouts abort any open frame. In IDLE they are
        // ignored.
        if (ld_state != L_IDLE && (frame_err || timeout)) ld_state_nx = L_IDLE;
    end

    always_comb begin
        abort       = (ld_state != L_IDLE) && (frame_err || timeout);
        start_frame = (ld_state == L_IDLE)   && byte_vld && (rx_byte == 8'hA5);
        len_hi_ld   = (ld_state == L_LEN_HI) && byte_vld;
        len_lo_ld   = (ld_state == L_LEN_LO) && byte_vld;
        data_wr     = (ld_state == L_DATA)   && byte_vld;
        done_set    = (ld_state == L_CSUM)   && byte_vld && (rx_byte == sum);
        err_set     = ((ld_state == L_CSUM)  && byte_vld && (rx_byte != sum)) || abort;
        cpu_hold    = (ld_state != L_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_waddr <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            len_hi    <= '0;
            len       <= '0;
            index     <= '0;
            sum       <= '0;
        end else begin
            ram_we <= data_wr;
            if (start_frame) begin
                index     <= '0;
                sum       <= '0;
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end
            if (len_hi_ld) len_hi <= rx_byte;
            if (len_lo_ld) len    <= {len_hi, rx_byte};
            if (data_wr) begin
                // The address wraps modulo 2**ADDR_WIDTH past the top of RAM.
                ram_waddr <= LOAD_BASE + ADDR_WIDTH'(index);
                ram_din   <= DATA_WIDTH'(rx_byte);
                index     <= index + 16'd1;
                sum       <= sum + rx_byte;
            end
            if (done_set) load_done <= 1'b1;
            if (err_set)  load_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
module tb_uart_ram_loader;

    localparam int CLK_DIV = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        rx_a, rx_b;
    logic [15:0] ram_waddr_a, ram_waddr_b;
    logic [7:0]  ram_din_a, ram_din_b;
    logic        ram_we_a, ram_we_b;
    logic        cpu_hold_a, cpu_hold_b;
    logic        load_done_a, load_done_b;
    logic        load_err_a, load_err_b;

    uart_ram_loader #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .LOAD_BASE(16'h0600),
        .CLK_DIV(CLK_DIV), .TIMEOUT_BITS(32)
    ) dut_a (
        .clk(clk), .rst(rst_a), .rx(rx_a),
        .ram_waddr(ram_waddr_a), .ram_din(ram_din_a), .ram_we(ram_we_a),
        .cpu_hold(cpu_hold_a), .load_done(load_done_a), .load_err(load_err_a)
    );

    uart_ram_loader #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .LOAD_BASE(16'hFFFF),
        .CLK_DIV(CLK_DIV), .TIMEOUT_BITS(32)
    ) dut_b (
        .clk(clk), .rst(rst_b), .rx(rx_b),
        .ram_waddr(ram_waddr_b), .ram_din(ram_din_b), .ram_we(ram_we_b),
        .cpu_hold(cpu_hold_b), .load_done(load_done_b), .load_err(load_err_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int we_cnt_a = 0;
    int we_cnt_b = 0;
    logic [23:0] exp_q[$];     // {addr, data} writes expected from dut_a
    logic [23:0] exp_q_b[$];   // {addr, data} writes expected from dut_b
    logic [7:0]  mem_a [0:65535];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        if (ram_we_a === 1'b1) begin
            we_cnt_a++;
            mem_a[ram_waddr_a] = ram_din_a;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            check("write_a", {8'h00, ram_waddr_a, ram_din_a}, {8'h00, e});
        end
        if (ram_we_b === 1'b1) begin
            we_cnt_b++;
            if (exp_q_b.size() != 0) e = exp_q_b.pop_front();
            else e = 'x;
            check("write_b", {8'h00, ram_waddr_b, ram_din_b}, {8'h00, e});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // One 8N1 character, then one idle bit-time.
    task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
        set_rx(sel, 1'b0);
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            tick(CLK_DIV);
        end
        set_rx(sel, stop);
        tick(CLK_DIV);
        set_rx(sel, 1'b1);
        tick(CLK_DIV);
    endtask

    task automatic exp_a(input logic [15:0] addr, input logic [7:0] data);
        exp_q.push_back({addr, data});
    endtask

    // ---------------- directed sequence ----------------
    int base;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        tick(3);

        // Reset state
        check("rst_hold",  {31'd0, cpu_hold_a},  32'd0);
        check("rst_done",  {31'd0, load_done_a}, 32'd0);
        check("rst_err",   {31'd0, load_err_a},  32'd0);
        check("rst_we",    {31'd0, ram_we_a},    32'd0);
        check("rst_waddr", {16'd0, ram_waddr_a}, 32'd0);
        check("rst_din",   {24'd0, ram_din_a},   32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(20 * CLK_DIV);
        check("idle_no_we",   we_cnt_a, 0);
        check("idle_no_hold", {31'd0, cpu_hold_a}, 32'd0);

        // Normal load: A5 00 03 A9 01 8D 37
        base = we_cnt_a;
        exp_a(16'h0600, 8'hA9);
        exp_a(16'h0601, 8'h01);
        exp_a(16'h0602, 8'h8D);
        send_byte(0, 8'hA5, 1);
        check("load_hold_on", {31'd0, cpu_hold_a}, 32'd1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h03, 1);
        send_byte(0, 8'hA9, 1);
        send_byte(0, 8'h01, 1);
        send_byte(0, 8'h8D, 1);
        check("load_hold_mid", {31'd0, cpu_hold_a}, 32'd1);
        send_byte(0, 8'h37, 1);
        check("load_done",  {31'd0, load_done_a}, 32'd1);
        check("load_err",   {31'd0, load_err_a},  32'd0);
        check("load_hold",  {31'd0, cpu_hold_a},  32'd0);
        check("load_we_n",  we_cnt_a - base, 3);
        check("mem_0600",   {24'd0, mem_a[16'h0600]}, 32'hA9);
        check("mem_0601",   {24'd0, mem_a[16'h0601]}, 32'h01);
        check("mem_0602",   {24'd0, mem_a[16'h0602]}, 32'h8D);
        check("load_drain", exp_q.size(), 0);

        // Bad checksum: A5 00 01 EA 00
        base = we_cnt_a;
        exp_a(16'h0600, 8'hEA);
        send_byte(0, 8'hA5, 1);
        check("bad_done_clr", {31'd0, load_done_a}, 32'd0);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h01, 1);
        send_byte(0, 8'hEA, 1);
        send_byte(0, 8'h00, 1);
        check("bad_err",   {31'd0, load_err_a},  32'd1);
        check("bad_done",  {31'd0, load_done_a}, 32'd0);
        check("bad_hold",  {31'd0, cpu_hold_a},  32'd0);
        check("bad_we_n",  we_cnt_a - base, 1);
        check("mem_bad",   {24'd0, mem_a[16'h0600]}, 32'hEA);

        // Junk then empty frame: 12 34 A5 00 00 00
        base = we_cnt_a;
        send_byte(0, 8'h12, 1);
        send_byte(0, 8'h34, 1);
        check("junk_hold", {31'd0, cpu_hold_a}, 32'd0);
        send_byte(0, 8'hA5, 1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h00, 1);
        check("empty_done", {31'd0, load_done_a}, 32'd1);
        check("empty_err",  {31'd0, load_err_a},  32'd0);
        check("empty_we_n", we_cnt_a - base, 0);

        // Stop bit forced low on the 2nd data byte
        base = we_cnt_a;
        exp_a(16'h0600, 8'h11);
        send_byte(0, 8'hA5, 1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h03, 1);
        send_byte(0, 8'h11, 1);
        send_byte(0, 8'h22, 0);
        check("ferr_err",  {31'd0, load_err_a},  32'd1);
        check("ferr_done", {31'd0, load_done_a}, 32'd0);
        check("ferr_hold", {31'd0, cpu_hold_a},  32'd0);
        check("ferr_we_n", we_cnt_a - base, 1);

        // Line idle for 40 bit-times mid-DATA
        base = we_cnt_a;
        exp_a(16'h0600, 8'h55);
        send_byte(0, 8'hA5, 1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h03, 1);
        send_byte(0, 8'h55, 1);
        tick(28 * CLK_DIV);
        check("to_early_hold", {31'd0, cpu_hold_a}, 32'd1);
        check("to_early_err",  {31'd0, load_err_a}, 32'd0);
        tick(10 * CLK_DIV);
        check("to_err",  {31'd0, load_err_a}, 32'd1);
        check("to_hold", {31'd0, cpu_hold_a}, 32'd0);
        check("to_we_n", we_cnt_a - base, 1);

        // Half-bit low glitch in IDLE, followed closely by a real frame
        base = we_cnt_a;
        rx_a = 1'b0;
        tick(CLK_DIV / 2);
        rx_a = 1'b1;
        tick(2 * CLK_DIV);
        check("glitch_hold", {31'd0, cpu_hold_a}, 32'd0);
        exp_a(16'h0600, 8'h42);
        send_byte(0, 8'hA5, 1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h01, 1);
        send_byte(0, 8'h42, 1);
        send_byte(0, 8'h42, 1);
        check("glitch_done", {31'd0, load_done_a}, 32'd1);
        check("glitch_we_n", we_cnt_a - base, 1);

        // rst after 2 of 4 data bytes, then a fresh frame
        base = we_cnt_a;
        exp_a(16'h0600, 8'h01);
        exp_a(16'h0601, 8'h02);
        send_byte(0, 8'hA5, 1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h04, 1);
        send_byte(0, 8'h01, 1);
        send_byte(0, 8'h02, 1);
        rst_a = 1'b1;
        tick(2);
        check("mid_rst_hold", {31'd0, cpu_hold_a},  32'd0);
        check("mid_rst_done", {31'd0, load_done_a}, 32'd0);
        check("mid_rst_err",  {31'd0, load_err_a},  32'd0);
        check("mid_rst_addr", {16'd0, ram_waddr_a}, 32'd0);
        rst_a = 1'b0;
        tick(1);
        send_byte(0, 8'h03, 1);
        send_byte(0, 8'h04, 1);
        check("post_rst_we_n", we_cnt_a - base, 2);
        check("post_rst_hold", {31'd0, cpu_hold_a}, 32'd0);
        exp_a(16'h0600, 8'hC0);
        exp_a(16'h0601, 8'hDE);
        send_byte(0, 8'hA5, 1);
        send_byte(0, 8'h00, 1);
        send_byte(0, 8'h02, 1);
        send_byte(0, 8'hC0, 1);
        send_byte(0, 8'hDE, 1);
        send_byte(0, 8'h9E, 1);
        check("fresh_done", {31'd0, load_done_a}, 32'd1);
        check("fresh_err",  {31'd0, load_err_a},  32'd0);
        check("fresh_we_n", we_cnt_a - base, 4);
        check("fresh_drain", exp_q.size(), 0);

        // Address wrap on dut_b (LOAD_BASE = FFFF)
        exp_q_b.push_back({16'hFFFF, 8'h10});
        exp_q_b.push_back({16'h0000, 8'h20});
        send_byte(1, 8'hA5, 1);
        send_byte(1, 8'h00, 1);
        send_byte(1, 8'h02, 1);
        send_byte(1, 8'h10, 1);
        send_byte(1, 8'h20, 1);
        send_byte(1, 8'h30, 1);
        check("wrap_done",  {31'd0, load_done_b}, 32'd1);
        check("wrap_hold",  {31'd0, cpu_hold_b},  32'd0);
        check("wrap_we_n",  we_cnt_b, 2);
        check("wrap_drain", exp_q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
